apb_master_arb2: RTL

- Two-requester APB master controller that shares one APB slave port between requester 0 and requester 1.
- Arbitrates round-robin and sequences the APB SETUP/ACCESS phases, including wait states (pready low).
- Returns read data and error status to the requester that was granted.
- Sits upstream of the APB slave-side FSM and drives its psel/penable/pwrite/paddr/pwdata.

---
 rtl/apb_arb_pkg.sv | 19 +
 rtl/apb_rr_arb2.sv | 20 ++
 rtl/apb_master_arb2.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/apb_arb_pkg.sv
// rtl/apb_arb_pkg.sv - state encoding, default widths and timeout counter sizing for apb_master_arb2
package apb_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETUP  = 2'd1;
  localparam state_t ACCESS = 2'd2;

  localparam int DEF_AW             = 32;
  localparam int DEF_DW             = 32;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Counter must be able to hold the limit value itself.
  function automatic int to_cnt_w(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// rtl/apb_rr_arb2.sv - combinational two-way round-robin picker
module apb_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_gnt;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/apb_master_arb2.sv
// rtl/apb_master_arb2.sv - two-requester round-robin APB master; ACCESS timeout built with APB_TIMEOUT_EN
module apb_master_arb2
  import apb_arb_pkg::*;
#(
  parameter int AW             = DEF_AW,
  parameter int DW             = DEF_DW,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_done,
  output logic [DW-1:0] req0_rdata,
  output logic          req0_err,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_done,
  output logic [DW-1:0] req1_rdata,
  output logic          req1_err,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [AW-1:0] paddr,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);

  state_t        state;
  logic          last_gnt;
  logic          owner;
  logic [1:0]    eligible;
  logic          gnt_valid;
  logic          gnt_id;
  logic          timed_out;
  logic          complete;
  logic          err_ret;
  logic [DW-1:0] rdata_ret;

  // A requester still holding valid in its own done cycle must not be regranted.
  assign eligible = {req1_valid & ~req1_done, req0_valid & ~req0_done};

  apb_rr_arb2 u_arb (
    .req       (eligible),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

`ifdef APB_TIMEOUT_EN
  localparam int            CW       = to_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready && wait_cnt != TO_LIMIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (state == ACCESS) && !pready && (wait_cnt == TO_LIMIT);
`else
  assign timed_out = 1'b0;

  // Parameter kept so both builds share one instantiation footprint.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
  end
`endif

  assign complete  = pready | timed_out;
  assign err_ret   = pready ? pslverr : 1'b1;
  assign rdata_ret = (pready && !pwrite) ? prdata : '0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      last_gnt   <= 1'b1;
      owner      <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      req0_done  <= 1'b0;
      req0_rdata <= '0;
      req0_err   <= 1'b0;
      req1_done  <= 1'b0;
      req1_rdata <= '0;
      req1_err   <= 1'b0;
    end else begin
      req0_done <= 1'b0;
      req1_done <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner    <= gnt_id;
            last_gnt <= gnt_id;
            pwrite   <= gnt_id ? req1_write : req0_write;
            paddr    <= gnt_id ? req1_addr  : req0_addr;
            pwdata   <= gnt_id ? req1_wdata : req0_wdata;
            psel     <= 1'b1;
            penable  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (complete) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            state   <= IDLE;
            if (owner) begin
              req1_done  <= 1'b1;
              req1_err   <= err_ret;
              req1_rdata <= rdata_ret;
            end else begin
              req0_done  <= 1'b1;
              req0_err   <= err_ret;
              req0_rdata <= rdata_ret;
            end
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule
